// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The read tag carries the memory target code; the default code is defined here when not supplied.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_t;

    localparam int LINE_BYTES      = 64;
    localparam int BEATS_PER_LINE  = 8;
    localparam int INSTRS_PER_BEAT = 2;
    localparam int INSTRS_PER_LINE = BEATS_PER_LINE * INSTRS_PER_BEAT;

    localparam logic [12:0] READ_TAG = {1'b1, `SYSBUS_MEMORY, 8'h00};

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return addr & ~64'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: up to two writes per cycle (entry 0 first), one read, synchronous flush.
// Entries are {pc[63:0], instr[31:0]}; free_cnt reports remaining slots.
module instr_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             push_cnt,
    input  logic [63:0]            pc0,
    input  logic [31:0]            instr0,
    input  logic [63:0]            pc1,
    input  logic [31:0]            instr1,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [63:0]            head_pc,
    output logic [31:0]            head_instr,
    output logic [$clog2(DEPTH):0] free_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [95:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [AW-1:0] wr_idx0;
    logic [AW-1:0] wr_idx1;
    logic [95:0]   head;
    logic          do_pop;

    assign count      = wr_ptr - rd_ptr;
    assign head_valid = (count != '0);
    assign free_cnt   = (AW + 1)'(DEPTH) - count;
    assign do_pop     = pop && head_valid && !flush;
    assign wr_idx0    = wr_ptr[AW-1:0];
    assign wr_idx1    = wr_ptr[AW-1:0] + AW'(1);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_pc    = head_valid ? head[95:32] : '0;
    assign head_instr = head_valid ? head[31:0] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW + 1)'(push_cnt);
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_cnt != 2'd0) begin
                mem[wr_idx0] <= {pc0, instr0};
            end
            if (push_cnt == 2'd2) begin
                mem[wr_idx1] <= {pc1, instr1};
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: line requests, beat splitting, redirect and end-of-program stop.
// Optional FETCH_TRACE_EN prints issued line addresses and redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [31:0]               instr,
    output logic [63:0]               instr_pc,
    output logic                      fetch_done,
    output logic [1:0]                dbg_state
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state, state_d;
    logic [63:0]   fetch_pc, fetch_pc_d;
    logic [63:0]   line_addr, line_addr_d;
    logic [63:0]   req_addr, req_addr_d;
    logic [2:0]    beat_cnt, beat_cnt_d;
    logic          discard, discard_d;
    logic          end_flag, end_d;
    logic          req_active, req_active_d;

    logic [FW-1:0] free_cnt;
    logic          redir;
    logic          beat;
    logic          last_beat;
    logic [63:0]   lo_addr;
    logic [63:0]   hi_addr;
    logic [31:0]   lo_word;
    logic [31:0]   hi_word;
    logic          lo_ok, lo_zero, hi_ok, hi_zero;
    logic          push_lo, push_hi;
    logic [1:0]    push_cnt;
    logic [63:0]   push_pc0;
    logic [31:0]   push_instr0;
    logic          unused_tag;

    assign unused_tag = ^bus_resptag;
    assign dbg_state  = state;

    assign redir     = redirect_valid && (state != ST_INIT);
    assign beat      = (state == ST_RESP) && bus_respcyc;
    assign last_beat = beat && (beat_cnt == 3'(BEATS_PER_LINE - 1));

    assign lo_addr = line_addr + {58'd0, beat_cnt, 3'd0};
    assign hi_addr = lo_addr + 64'd4;
    assign lo_word = bus_resp[31:0];
    assign hi_word = bus_resp[63:32];

    // A zero word only terminates when it would otherwise have been delivered.
    assign lo_ok   = beat && !discard && !end_flag && (lo_addr >= fetch_pc);
    assign lo_zero = lo_ok && (lo_word == 32'h0);
    assign hi_ok   = beat && !discard && !end_flag && !lo_zero && (hi_addr >= fetch_pc);
    assign hi_zero = hi_ok && (hi_word == 32'h0);
    assign push_lo = lo_ok && !lo_zero;
    assign push_hi = hi_ok && !hi_zero;

    assign push_cnt    = redir ? 2'd0 : ({1'b0, push_lo} + {1'b0, push_hi});
    assign push_pc0    = push_lo ? lo_addr : hi_addr;
    assign push_instr0 = push_lo ? lo_word : hi_word;

    // Once raised, the request is held at its original address until acknowledged.
    assign bus_reqcyc  = (state == ST_REQ) &&
                         (req_active || (free_cnt >= FW'(INSTRS_PER_LINE)));
    assign bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(req_active ? req_addr : line_addr) : '0;
    assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(READ_TAG) : '0;
    assign bus_respack = beat;

    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        line_addr_d  = line_addr;
        req_addr_d   = req_addr;
        beat_cnt_d   = beat_cnt;
        discard_d    = discard;
        end_d        = end_flag;
        req_active_d = req_active;

        unique case (state)
            ST_INIT: begin
                state_d     = ST_REQ;
                fetch_pc_d  = entry;
                line_addr_d = line_base(entry);
            end
            ST_REQ: begin
                if (bus_reqcyc) begin
                    if (bus_reqack) begin
                        state_d      = ST_RESP;
                        beat_cnt_d   = 3'd0;
                        req_active_d = 1'b0;
                    end else begin
                        req_active_d = 1'b1;
                        req_addr_d   = 64'(bus_req);
                    end
                end
            end
            ST_RESP: begin
                if (bus_respcyc) begin
                    beat_cnt_d = beat_cnt + 3'd1;
                    if (lo_zero || hi_zero) begin
                        end_d = 1'b1;
                    end
                    if (last_beat) begin
                        if (discard) begin
                            state_d   = ST_REQ;
                            discard_d = 1'b0;
                        end else begin
                            line_addr_d = line_addr + 64'(LINE_BYTES);
                            fetch_pc_d  = line_addr + 64'(LINE_BYTES);
                            state_d     = end_d ? ST_DONE : ST_REQ;
                        end
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_INIT;
        endcase

        // Redirect overrides normal progress; a request already on the bus is drained unused.
        if (redir) begin
            fetch_pc_d  = redirect_pc;
            line_addr_d = line_base(redirect_pc);
            end_d       = 1'b0;
            unique case (state)
                ST_REQ: begin
                    if (bus_reqcyc) begin
                        discard_d = 1'b1;
                    end
                end
                ST_RESP: begin
                    if (last_beat) begin
                        state_d   = ST_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_REQ;
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            fetch_pc   <= '0;
            line_addr  <= '0;
            req_addr   <= '0;
            beat_cnt   <= '0;
            discard    <= 1'b0;
            end_flag   <= 1'b0;
            req_active <= 1'b0;
        end else begin
            state      <= state_d;
            fetch_pc   <= fetch_pc_d;
            line_addr  <= line_addr_d;
            req_addr   <= req_addr_d;
            beat_cnt   <= beat_cnt_d;
            discard    <= discard_d;
            end_flag   <= end_d;
            req_active <= req_active_d;
        end
    end

    instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redir),
        .push_cnt   (push_cnt),
        .pc0        (push_pc0),
        .instr0     (push_instr0),
        .pc1        (hi_addr),
        .instr1     (hi_word),
        .pop        (instr_ready),
        .head_valid (instr_valid),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .free_cnt   (free_cnt)
    );

    assign fetch_done = (state == ST_DONE) && !instr_valid;

`ifdef FETCH_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (bus_reqcyc && bus_reqack) begin
                $display("fetch line 0x%x", bus_req);
            end
            if (redir) begin
                $display("redirect 0x%x", redirect_pc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a bus memory responder, a reference instruction stream
// derived from the memory image, and a monitor that scores every delivered instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        fetch_done;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_respack    (bus_respack),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_done     (fetch_done),
        .dbg_state      (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [95:0] exp_q[$];
    logic [63:0] exp_req[$];
    logic [31:0] ovr[logic [63:0]];

    int          ready_mode = 1;
    int          redir_beat = -1;
    int          reset_beat = -1;
    logic [63:0] redir_target = '0;
    logic        did_reset = 1'b0;
    int          reqs_seen = 0;
    int          pops = 0;
    logic [63:0] first_pc = '0;
    logic [63:0] last_pc = '0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Memory image: a nonzero hash everywhere except explicit overrides.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (ovr.exists(a)) return ovr[a];
        return ((a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0000) | 32'h1;
    endfunction

    // Program order from start up to (not including) the first zero word, plus the lines read.
    task automatic build(input logic [63:0] start);
        logic [63:0] pc;
        logic [31:0] w;
        exp_q.delete();
        exp_req.delete();
        pc = start;
        exp_req.push_back(start & ~64'd63);
        for (int n = 0; n < 2048; n++) begin
            w = mem_word(pc);
            if (w == 32'h0) break;
            exp_q.push_back({pc, w});
            pc = pc + 64'd4;
            if (pc[5:0] == 6'd0) exp_req.push_back(pc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got 0x%0h@0x%0h expected none", instr, instr_pc);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                check("instr_pc", 96'(instr_pc), 96'(e[95:32]));
                check("instr", 96'(instr), 96'(e[31:0]));
                if (pops == 0) first_pc = instr_pc;
                last_pc = instr_pc;
                pops++;
            end
        end
    end

    initial begin : ready_driver
        instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) instr_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 0) instr_ready = 1'b0;
        end
    end

    task automatic serve();
        logic [63:0] line;
        line = bus_req;
        reqs_seen++;
        check("req_tag", 96'(bus_reqtag), 96'(13'h1100));
        if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_request: got 0x%0h expected none", line);
        end else begin
            check("req_addr", 96'(line), 96'(exp_req.pop_front()));
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1 bus_reqack = 1'b1;
        @(posedge clk);
        #1 bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic redir_now;
            redir_now = 1'b0;
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            bus_respcyc = 1'b1;
            bus_resp    = {mem_word(line + 64'(8 * k) + 64'd4), mem_word(line + 64'(8 * k))};
            bus_resptag = 13'($urandom);
            if (k == redir_beat) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_target;
                redir_beat     = -1;
                redir_now      = 1'b1;
                build(redir_target);
            end
            if (k == reset_beat) begin
                reset      = 1'b0;
                reset_beat = -1;
                #1;
                check("rst_reqcyc", 96'(bus_reqcyc), 96'(0));
                check("rst_respack", 96'(bus_respack), 96'(0));
                check("rst_valid", 96'(instr_valid), 96'(0));
                bus_respcyc = 1'b0;
                did_reset   = 1'b1;
                return;
            end
            @(negedge clk);
            check("respack", 96'(bus_respack), 96'(1));
            @(posedge clk);
            #1;
            bus_respcyc    = 1'b0;
            redirect_valid = 1'b0;
            if (redir_now) begin
                @(negedge clk);
                check("valid_after_redirect", 96'(instr_valid), 96'(0));
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : responder
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        forever begin
            @(negedge clk);
            if (reset && bus_reqcyc) serve();
        end
    end

    task automatic start(input logic [63:0] e);
        reset          = 1'b0;
        entry          = e;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pops           = 0;
        reqs_seen      = 0;
        build(e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_reqcyc", 96'(bus_reqcyc), 96'(0));
        check("rst_bus_req", 96'(bus_req), 96'(0));
        check("rst_bus_reqtag", 96'(bus_reqtag), 96'(0));
        check("rst_instr_valid", 96'(instr_valid), 96'(0));
        check("rst_instr", 96'(instr), 96'(0));
        check("rst_instr_pc", 96'(instr_pc), 96'(0));
        check("rst_fetch_done", 96'(fetch_done), 96'(0));
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (fetch_done && exp_q.size() == 0) break;
        end
        check("fetch_done", 96'(fetch_done), 96'(1));
        check("exp_q_drained", 96'(exp_q.size()), 96'(0));
        check("exp_req_drained", 96'(exp_req.size()), 96'(0));
        repeat (20) @(negedge clk);
        check("fetch_done_hold", 96'(fetch_done), 96'(1));
    endtask

    initial begin
        reset          = 1'b0;
        entry          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Basic line at 0x1000 with known first beat; stream ends in the third line.
        ovr.delete();
        ovr[64'h1000] = 32'h00100093;
        ovr[64'h1004] = 32'h00000013;
        ovr[64'h1090] = 32'h0;
        ready_mode = 1;
        start(64'h1000);
        wait_done();
        check("s1_first_pc", 96'(first_pc), 96'(64'h1000));
        check("s1_reqs", 96'(reqs_seen), 96'(3));

        // Unaligned entry drops words below the entry PC.
        ovr.delete();
        ovr[64'h1040] = 32'h0;
        start(64'h1008);
        wait_done();
        check("s2_first_pc", 96'(first_pc), 96'(64'h1008));
        check("s2_pops", 96'(pops), 96'(14));

        // Back-pressure: two lines fill the FIFO, 16 pops reopen the request.
        ovr.delete();
        ovr[64'h1200] = 32'h0;
        ready_mode = 0;
        start(64'h1000);
        repeat (200) @(negedge clk);
        check("s3_reqs_full", 96'(reqs_seen), 96'(2));
        check("s3_no_req_full", 96'(bus_reqcyc), 96'(0));
        check("s3_valid_full", 96'(instr_valid), 96'(1));
        ready_mode = 2;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 instr_ready = 1'b1;
        end
        @(posedge clk);
        #1 instr_ready = 1'b0;
        @(negedge clk);
        check("s3_pops", 96'(pops), 96'(16));
        check("s3_reqcyc_again", 96'(bus_reqcyc), 96'(1));
        check("s3_req_addr", 96'(bus_req), 96'(64'h1080));
        ready_mode = 1;
        wait_done();

        // Zero low word of beat 3, then a redirect out of the finished state.
        ovr.delete();
        ovr[64'h1018] = 32'h0;
        ovr[64'h1050] = 32'h0;
        start(64'h1000);
        wait_done();
        check("s4_last_pc", 96'(last_pc), 96'(64'h1014));
        check("s4_pops", 96'(pops), 96'(6));
        check("s4_reqs", 96'(reqs_seen), 96'(1));
        pops = 0;
        build(64'h1040);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1040;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        wait_done();
        check("s4_redirect_pops", 96'(pops), 96'(4));

        // Redirect in the middle of a burst.
        ovr.delete();
        ovr[64'h1400] = 32'h0;
        ovr[64'h2030] = 32'h0;
        redir_beat   = 2;
        redir_target = 64'h2000;
        start(64'h1000);
        wait_done();
        check("s5_last_pc", 96'(last_pc), 96'(64'h202C));

        // Reset in the middle of a burst restarts from the entry line.
        ovr.delete();
        ovr[64'h3100] = 32'h0;
        did_reset  = 1'b0;
        reset_beat = 4;
        start(64'h3000);
        for (int i = 0; i < 500 && !did_reset; i++) @(negedge clk);
        check("s6_reset_hit", 96'(did_reset), 96'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        pops = 0;
        build(64'h3000);
        reset = 1'b1;
        wait_done();
        check("s6_first_pc", 96'(first_pc), 96'(64'h3000));
        check("s6_pops", 96'(pops), 96'(64));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
